l2_port_arbiter: RTL and testbench
==================================

Name: l2_port_arbiter

Overview:
- Shares the single line-wide L2 cache port between the L1 instruction cache (read-only) and the L1 data cache (read/write).
- Sits between both L1 miss paths and the L2 cache control/datapath.
- Grants one requester at a time, latches its address and write line, and holds the L2 request until the L2 returns mem_resp.
- Round-robin on simultaneous requests; one-cycle release gap after every transaction.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 256, cache line width in bits

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous, active-low reset (0 = reset)
i_read  in  1  I-cache line read request
i_addr  in  ADDR_W  I-cache line address
i_rdata  out  LINE_W  read line to I-cache
i_resp  out  1  I-cache transaction complete
d_read  in  1  D-cache line read request
d_write  in  1  D-cache line write request
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache write line
d_rdata  out  LINE_W  read line to D-cache
d_resp  out  1  D-cache transaction complete
l2_read  out  1  L2 read request
l2_write  out  1  L2 write request
l2_addr  out  ADDR_W  L2 address
l2_wdata  out  LINE_W  L2 write line
l2_rdata  in  LINE_W  L2 read line
l2_resp  in  1  L2 transaction complete
grant_d  out  1  status: 1 = D-cache owns port (valid in BUSY only)

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, last_grant=I, owner=I, addr_q=0, wdata_q=0, op_q=read. All outputs 0 immediately, no clock edge required. Reset mid-transaction abandons the transaction; no resp is issued.
- States: IDLE, BUSY, DONE.
- IDLE:
  - req_i = i_read; req_d = d_read | d_write.
  - Only req_i: grant I. Only req_d: grant D. Both: grant the requester not in last_grant.
  - On grant, latch at the edge: owner, addr_q, op_q (d_write wins if d_read and d_write are both high), wdata_q (d_wdata for D, else 0). Set last_grant=owner. Next state BUSY.
  - No request: stay IDLE.
  - l2_read/l2_write are 0 in IDLE (one-cycle grant latency).
- BUSY:
  - l2_addr=addr_q, l2_wdata=wdata_q.
  - l2_read=(op_q==read), l2_write=(op_q==write). Held stable until l2_resp.
  - grant_d=(owner==D).
  - Requester inputs are ignored. A dropped or changed request does not abort the transaction.
  - When l2_resp=1: i_resp (owner I) or d_resp (owner D) is 1 combinationally in the same cycle. Next state DONE.
- DONE:
  - All L2 requests deasserted; all new requests ignored. Next state IDLE unconditionally.
  - Purpose: the L1 controller drops its stale request, and the L2 controller returns to idle.
- i_rdata and d_rdata = l2_rdata at all times; valid only when the matching resp=1.
- Resp pulses last exactly one cycle per transaction. Never both resps in one cycle.
- l2_resp outside BUSY is ignored.
- Throughput: at most one transaction per (3 + L2 latency) cycles. Alternating fairness bounds starvation to one foreign transaction.

Test Plan:
- Reset with i_read=1 and d_read=1 held: first grant to D (last_grant=I). l2_read=1 and l2_addr=d_addr on the cycle after the grant. Second grant after DONE goes to I.
- d_write=1, d_addr=0x0000_1A40, d_wdata=pattern A5..A5; l2_resp asserted 4 cycles later -> l2_write held 4 cycles with stable addr/wdata, d_resp=1 for exactly one cycle coincident with l2_resp, i_resp=0 throughout.
- I-cache read of 0x0000_0100; l2_rdata=0xDEAD... during l2_resp -> i_rdata matches in the i_resp cycle. Next IDLE is reached 2 cycles after l2_resp.
- d_read and d_write both high -> l2_write=1, l2_read=0.
- BUSY on I; d_addr changes and i_read drops mid-transaction -> l2_addr unchanged, transaction completes with i_resp.
- Reset low during BUSY -> l2_read=0 and state=IDLE asynchronously. After release, a pending request is regranted cleanly with no spurious resp.
- Spurious l2_resp in IDLE/DONE -> no i_resp/d_resp.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: round-robin share of one line-wide L2 port between the L1 I-cache and D-cache
module l2_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_addr,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic [LINE_W-1:0] l2_rdata,
   input  logic              l2_resp,
   output logic              grant_d
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t            state, state_nxt;
   // owner_d doubles as last_grant: the owner of a transaction is by definition the last one granted
   logic              owner_d;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic              req_i, req_d, pick_d, busy;
   assign req_i  = i_read;
   assign req_d  = d_read | d_write;
   assign pick_d = req_d & (~req_i | ~owner_d);
   assign busy   = state == BUSY;
   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end
   // next-state: grant from IDLE, wait for L2 in BUSY, one release cycle in DONE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = (req_i | req_d) ? BUSY : IDLE;
         BUSY:    state_nxt = l2_resp ? DONE : BUSY;
         default: state_nxt = IDLE;
      endcase
   end
   // latch the winner's transaction at the grant edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_d <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (state == IDLE && (req_i | req_d)) begin
         owner_d <= pick_d;
         write_q <= pick_d & d_write;
         addr_q  <= pick_d ? d_addr : i_addr;
         wdata_q <= pick_d ? d_wdata : '0;
      end
   end
   // outputs: L2 request only while BUSY, responses routed to the owner
   always_comb begin
      l2_read  = busy & ~write_q;
      l2_write = busy & write_q;
      l2_addr  = busy ? addr_q : '0;
      l2_wdata = busy ? wdata_q : '0;
      grant_d  = busy & owner_d;
      i_resp   = busy & l2_resp & ~owner_d;
      d_resp   = busy & l2_resp & owner_d;
      i_rdata  = l2_rdata;
      d_rdata  = l2_rdata;
   end
endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: transaction-level reference checks of the L2 port arbiter
module tb_l2_port_arbiter;
   localparam int AW = 32;
   localparam int LW = 256;
   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, l2_resp = 1'b0;
   logic [AW-1:0] i_addr = '0, d_addr = '0;
   logic [LW-1:0] d_wdata = '0, l2_rdata = '0;
   logic [LW-1:0] i_rdata, d_rdata, l2_wdata;
   logic [AW-1:0] l2_addr;
   logic          i_resp, d_resp, l2_read, l2_write, grant_d;
   int            n_chk = 0;
   int            n_fail = 0;
   logic          last_d = 1'b0;

   l2_port_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
      .l2_rdata(l2_rdata), .l2_resp(l2_resp), .grant_d(grant_d)
   );

   always #5 clk = ~clk;

   function automatic logic [LW-1:0] rnd_line();
      logic [LW-1:0] v;
      for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One transaction from its IDLE cycle to the start of the following IDLE cycle.
   // lat = number of BUSY cycles before the one carrying l2_resp.
   task automatic txn(input logic ir, input logic dr, input logic dw,
                      input logic [AW-1:0] ia, input logic [AW-1:0] da,
                      input logic [LW-1:0] wd, input int lat, input logic [LW-1:0] rd,
                      input logic perturb, input logic spur);
      logic          win, wr;
      logic [AW-1:0] ea;
      logic [LW-1:0] ew;
      #1;
      i_read = ir; d_read = dr; d_write = dw;
      i_addr = ia; d_addr = da; d_wdata = wd; l2_resp = spur;
      win = (dr | dw) && (!ir || !last_d);
      wr  = win && dw;
      ea  = win ? da : ia;
      ew  = win ? wd : '0;
      last_d = win;
      #1;
      chk("idle_l2_read", l2_read, 1'b0);
      chk("idle_l2_write", l2_write, 1'b0);
      chk("idle_i_resp", i_resp, 1'b0);
      chk("idle_d_resp", d_resp, 1'b0);
      for (int k = 0; k <= lat; k++) begin
         @(posedge clk);
         #1;
         l2_resp  = (k == lat);
         l2_rdata = (k == lat) ? rd : rnd_line();
         if (perturb) begin
            i_read = 1'b0; d_read = 1'($urandom); d_write = 1'($urandom);
            i_addr = $urandom; d_addr = $urandom; d_wdata = rnd_line();
         end
         #1;
         chk("busy_l2_read", l2_read, !wr);
         chk("busy_l2_write", l2_write, wr);
         chkw("busy_l2_addr", LW'(l2_addr), LW'(ea));
         chkw("busy_l2_wdata", l2_wdata, ew);
         chk("busy_grant_d", grant_d, win);
         chk("busy_i_resp", i_resp, (k == lat) && !win);
         chk("busy_d_resp", d_resp, (k == lat) && win);
         if (k == lat) begin
            chkw("resp_i_rdata", i_rdata, rd);
            chkw("resp_d_rdata", d_rdata, rd);
         end
      end
      @(posedge clk);
      #1;
      l2_resp = spur;
      i_read = 1'($urandom); d_read = 1'($urandom); d_write = 1'($urandom);
      #1;
      chk("done_l2_read", l2_read, 1'b0);
      chk("done_l2_write", l2_write, 1'b0);
      chk("done_i_resp", i_resp, 1'b0);
      chk("done_d_resp", d_resp, 1'b0);
      @(posedge clk);
   endtask

   initial begin
      logic [2:0] r;
      // reset with both caches requesting: nothing driven toward L2
      i_read = 1'b1; d_read = 1'b1;
      #2;
      chk("rst_l2_read", l2_read, 1'b0);
      chk("rst_l2_write", l2_write, 1'b0);
      chkw("rst_l2_addr", LW'(l2_addr), '0);
      chkw("rst_l2_wdata", l2_wdata, '0);
      chk("rst_i_resp", i_resp, 1'b0);
      chk("rst_d_resp", d_resp, 1'b0);
      chk("rst_grant_d", grant_d, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      // simultaneous requests alternate, starting with D
      txn(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0080, rnd_line(), 1, rnd_line(), 1'b0, 1'b0);
      txn(1'b1, 1'b1, 1'b0, 32'h0000_00C0, 32'h0000_0100, rnd_line(), 0, rnd_line(), 1'b0, 1'b0);
      // D write held four BUSY cycles
      txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_1A40, {32{8'hA5}}, 3, rnd_line(), 1'b0, 1'b0);
      // I read returning DEAD pattern
      txn(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, rnd_line(), 2, {8{32'hDEAD_BEEF}}, 1'b0, 1'b0);
      // read and write together: write wins
      txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_2000, rnd_line(), 1, rnd_line(), 1'b0, 1'b0);
      // requester inputs change mid-transaction
      txn(1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_4000, rnd_line(), 3, rnd_line(), 1'b1, 1'b0);
      // spurious l2_resp in IDLE and DONE
      txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_5000, rnd_line(), 2, rnd_line(), 1'b0, 1'b1);
      // asynchronous reset in the middle of an I read
      #1;
      i_read = 1'b1; i_addr = 32'h0000_0200; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
      @(posedge clk);
      #2;
      chk("pre_rst_l2_read", l2_read, 1'b1);
      rst = 1'b0;
      l2_resp = 1'b1;
      #1;
      chk("arst_l2_read", l2_read, 1'b0);
      chkw("arst_l2_addr", LW'(l2_addr), '0);
      chk("arst_i_resp", i_resp, 1'b0);
      chk("arst_d_resp", d_resp, 1'b0);
      last_d = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      l2_resp = 1'b0;
      txn(1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0, rnd_line(), 1, rnd_line(), 1'b0, 1'b0);
      // randomized traffic
      for (int t = 0; t < 60; t++) begin
         do r = 3'($urandom); while (r == 3'b000);
         txn(r[2], r[1], r[0], $urandom, $urandom, rnd_line(), int'($urandom_range(0, 5)),
             rnd_line(), 1'($urandom), 1'($urandom));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
